lpc_predictor_bank: RTL and testbench

LPC_PREDICTOR_BANK -- requirements
Module: lpc_predictor_bank

---
 rtl/lpc_pkg.sv | 31 +++
 rtl/lpc_order_lane.sv | 87 ++++++++
 rtl/lpc_predictor_bank.sv | 162 ++++++++++++++++
 tb/tb_lpc_predictor_bank.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// lpc_pkg: shared FSM state type and datapath width helpers for the
// LPC predictor bank (sum, residual and accumulator widths).
package lpc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SELECT
  } lpc_state_e;

  localparam int DRAIN_CYC = 3;

  // full-precision predictor sum: one product plus growth for MAX_ORDER terms
  function automatic int lpc_sum_w(int sw, int cw, int mo);
    return sw + cw + $clog2(mo);
  endfunction

  // x - pred needs one extra bit over the sum
  function automatic int lpc_res_w(int sw, int cw, int mo);
    return lpc_sum_w(sw, cw, mo) + 1;
  endfunction

  // room for a whole block of worst-case magnitudes
  function automatic int lpc_err_w(int sw, int cw, int mo, int bs);
    return lpc_res_w(sw, cw, mo) + $clog2(bs);
  endfunction

  localparam int ERR_W = lpc_err_w(16, 12, 12, 4096);

endpackage

// File: rtl/lpc_order_lane.sv
// lpc_order_lane: one predictor order -- coefficients, MAC, residual, sum.
// Ports: clk/rst/en, ld+coeff write, clr, stage-1 sample bundle in, acc out.
module lpc_order_lane
  import lpc_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int COEFF_W   = 12,
  parameter int MAX_ORDER = 12,
  parameter int ORDER     = 1,
  parameter int CNT_W     = 12,
  parameter int EW        = 45
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       ld,
  input  logic signed [COEFF_W-1:0]  coeff,
  input  logic                       clr,
  input  logic                       in_v,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [SAMPLE_W-1:0] win [MAX_ORDER],
  input  logic [CNT_W-1:0]           n,
  input  logic [4:0]                 shift,
  output logic [EW-1:0]              acc
);

  localparam int PW = SAMPLE_W + COEFF_W;
  localparam int SW = lpc_sum_w(SAMPLE_W, COEFF_W, MAX_ORDER);
  localparam int RW = lpc_res_w(SAMPLE_W, COEFF_W, MAX_ORDER);
  localparam int NC = (ORDER > 0) ? ORDER : 1;
  localparam int OW = $clog2(MAX_ORDER + 1);

  logic [OW-1:0]              ptr;
  logic signed [COEFF_W-1:0]  coef [NC];
  logic signed [PW-1:0]       prod [NC];
  logic                       a_v;
  logic                       b_v;
  logic signed [SAMPLE_W-1:0] a_x;
  logic [RW-1:0]              b_mag;
  logic signed [SW-1:0]       sum;
  logic signed [SW-1:0]       pred;
  logic signed [RW-1:0]       res;
  logic [EW:0]                acc_nx;

  always_comb begin
    sum = '0;
    for (int j = 0; j < ORDER; j++)
      sum = sum + SW'(prod[j]);
    pred = sum >>> shift;
    res = RW'(a_x) - RW'(pred);
  end

  assign acc_nx = {1'b0, acc} + (EW+1)'(b_mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      a_v   <= 1'b0;
      b_v   <= 1'b0;
      a_x   <= '0;
      b_mag <= '0;
      acc   <= '0;
      for (int j = 0; j < NC; j++) begin
        coef[j] <= '0;
        prod[j] <= '0;
      end
    end else if (en) begin
      if (ld && int'(ptr) < ORDER) begin
        for (int j = 0; j < NC; j++)
          if (int'(ptr) == j) coef[j] <= coeff;
        ptr <= ptr + 1'b1;
      end
      // warm-up samples never reach the accumulator
      a_v <= in_v && (int'(n) >= ORDER);
      a_x <= x;
      for (int j = 0; j < NC; j++)
        prod[j] <= coef[j] * win[j];
      b_v   <= a_v;
      b_mag <= res[RW-1] ? RW'(-res) : RW'(res);
      if (clr)
        acc <= '0;
      else if (b_v)
        acc <= acc_nx[EW] ? '1 : acc_nx[EW-1:0];
    end
  end

endmodule

// File: rtl/lpc_predictor_bank.sv
// lpc_predictor_bank: picks the LPC order with least absolute residual sum.
// Ports: iLoad/iM/iCoeff writes, iValid/iSample stream, oDone/oBest* result.
module lpc_predictor_bank
  import lpc_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int COEFF_W    = 12,
  parameter int MAX_ORDER  = 12,
  parameter int BLOCK_SIZE = 4096
) (
  input  logic                               iClock,
  input  logic                               iReset,
  input  logic                               iEnable,
  input  logic                               iLoad,
  input  logic [$clog2(MAX_ORDER+1)-1:0]     iM,
  input  logic signed [COEFF_W-1:0]          iCoeff,
  input  logic [4:0]                         iShift,
  input  logic                               iValid,
  input  logic signed [SAMPLE_W-1:0]         iSample,
  output logic                               oBusy,
  output logic                               oDone,
  output logic [$clog2(MAX_ORDER+1)-1:0]     oBestPredictor,
  output logic [lpc_err_w(SAMPLE_W, COEFF_W, MAX_ORDER, BLOCK_SIZE)-1:0] oBestError
);

  localparam int OW = $clog2(MAX_ORDER + 1);
  localparam int EW = lpc_err_w(SAMPLE_W, COEFF_W, MAX_ORDER, BLOCK_SIZE);
  localparam int CW = $clog2(BLOCK_SIZE);

  lpc_state_e                 state;
  logic [CW-1:0]              cnt;
  logic [1:0]                 dcnt;
  logic [OW-1:0]              sidx;
  logic [OW-1:0]              best_idx;
  logic [EW-1:0]              best_err;
  logic [4:0]                 shift_r;
  logic signed [SAMPLE_W-1:0] hist [MAX_ORDER];
  logic signed [SAMPLE_W-1:0] s1_win [MAX_ORDER];
  logic signed [SAMPLE_W-1:0] s1_x;
  logic [CW-1:0]              s1_n;
  logic                       s1_v;
  logic [EW-1:0]              acc [MAX_ORDER+1];
  logic                       accept;
  logic                       ld_ok;
  logic                       last;
  logic                       take;
  logic [EW-1:0]              cur;

  assign accept = iEnable && iValid &&
                  (state == S_IDLE || state == S_RUN);
  assign ld_ok  = iEnable && iLoad && (state == S_IDLE);
  assign last   = iEnable && (state == S_SELECT) &&
                  (int'(sidx) == MAX_ORDER);
  assign cur    = acc[sidx];
  // strict less-than: ties keep the lower order
  assign take   = (sidx == '0) || (cur < best_err);
  assign oBusy  = (state != S_IDLE);

  for (genvar m = 0; m <= MAX_ORDER; m++) begin : g_lane
    lpc_order_lane #(
      .SAMPLE_W (SAMPLE_W),
      .COEFF_W  (COEFF_W),
      .MAX_ORDER(MAX_ORDER),
      .ORDER    (m),
      .CNT_W    (CW),
      .EW       (EW)
    ) u_lane (
      .clk  (iClock),
      .rst  (iReset),
      .en   (iEnable),
      .ld   (ld_ok && (int'(iM) == m)),
      .coeff(iCoeff),
      .clr  (last),
      .in_v (s1_v),
      .x    (s1_x),
      .win  (s1_win),
      .n    (s1_n),
      .shift(shift_r),
      .acc  (acc[m])
    );
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      dcnt           <= '0;
      sidx           <= '0;
      best_idx       <= '0;
      best_err       <= '0;
      shift_r        <= '0;
      s1_v           <= 1'b0;
      s1_x           <= '0;
      s1_n           <= '0;
      oDone          <= 1'b0;
      oBestPredictor <= '0;
      oBestError     <= '0;
      for (int i = 0; i < MAX_ORDER; i++) begin
        hist[i]   <= '0;
        s1_win[i] <= '0;
      end
    end else begin
      oDone <= 1'b0;
      if (iEnable) begin
        s1_v <= accept;
        if (accept) begin
          s1_x   <= iSample;
          s1_n   <= cnt;
          s1_win <= hist;
          hist[0] <= iSample;
          for (int i = 1; i < MAX_ORDER; i++)
            hist[i] <= hist[i-1];
        end
        unique case (state)
          S_IDLE: begin
            if (accept) begin
              state   <= S_RUN;
              cnt     <= CW'(1);
              shift_r <= iShift;
            end
          end
          S_RUN: begin
            if (accept) begin
              if (cnt == CW'(BLOCK_SIZE - 1)) begin
                state <= S_DRAIN;
                cnt   <= '0;
                dcnt  <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            dcnt <= dcnt + 1'b1;
            if (dcnt == 2'(DRAIN_CYC - 1)) begin
              state <= S_SELECT;
              sidx  <= '0;
            end
          end
          S_SELECT: begin
            if (take) begin
              best_idx <= sidx;
              best_err <= cur;
            end
            if (last) begin
              oBestPredictor <= take ? sidx : best_idx;
              oBestError     <= take ? cur : best_err;
              oDone          <= 1'b1;
              state          <= S_IDLE;
              for (int i = 0; i < MAX_ORDER; i++)
                hist[i] <= '0;
            end else begin
              sidx <= sidx + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_predictor_bank.sv
// tb_lpc_predictor_bank: randomized bench for lpc_predictor_bank against
// an arithmetic reference model of the per-order residual sums.
module tb_lpc_predictor_bank;
  import lpc_pkg::*;

  localparam int SW = 16;
  localparam int CW = 12;
  localparam int MO = 12;
  localparam int BS = 16;
  localparam int EW = lpc_err_w(SW, CW, MO, BS);

  logic                 iClock = 1'b0;
  logic                 iReset;
  logic                 iEnable;
  logic                 iLoad;
  logic [3:0]           iM;
  logic signed [CW-1:0] iCoeff;
  logic [4:0]           iShift;
  logic                 iValid;
  logic signed [SW-1:0] iSample;
  logic                 oBusy;
  logic                 oDone;
  logic [3:0]           oBestPredictor;
  logic [EW-1:0]        oBestError;

  int     tests = 0;
  int     fails = 0;
  int     cm [MO+1][MO];
  int     cp [MO+1];
  int     xs [BS];
  int     sh;
  int     m_bp;
  longint m_be;
  int     done_cnt;
  int     sv_bp;
  longint sv_be;

  lpc_predictor_bank #(
    .SAMPLE_W  (SW),
    .COEFF_W   (CW),
    .MAX_ORDER (MO),
    .BLOCK_SIZE(BS)
  ) dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iLoad         (iLoad),
    .iM            (iM),
    .iCoeff        (iCoeff),
    .iShift        (iShift),
    .iValid        (iValid),
    .iSample       (iSample),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oBestPredictor(oBestPredictor),
    .oBestError    (oBestError)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m <= MO; m++) begin
      cp[m] = 0;
      for (int j = 0; j < MO; j++) cm[m][j] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge iClock);
    iReset = 1'b1; iEnable = 1'b0; iLoad = 1'b0; iValid = 1'b0;
    @(negedge iClock);
    iReset = 1'b0; iEnable = 1'b1;
    model_clear();
  endtask

  // one write in IDLE; the model applies the acceptance rules
  task automatic load(input int m, input int c);
    @(negedge iClock);
    iEnable = 1'b1; iLoad = 1'b1; iM = 4'(m); iCoeff = 12'(c);
    @(negedge iClock);
    iLoad = 1'b0;
    if (m >= 1 && m <= MO && cp[m] < m) begin
      cm[m][cp[m]] = c;
      cp[m]++;
    end
  endtask

  task automatic model();
    longint s, p, r;
    m_bp = 0;
    m_be = 0;
    for (int m = 0; m <= MO; m++) begin
      s = 0;
      for (int n = m; n < BS; n++) begin
        p = 0;
        for (int j = 0; j < m; j++)
          p += longint'(cm[m][j]) * longint'(xs[n-1-j]);
        p = p >>> sh;
        r = longint'(xs[n]) - p;
        s += (r < 0) ? -r : r;
      end
      if (m == 0 || s < m_be) begin
        m_bp = m;
        m_be = s;
      end
    end
  endtask

  task automatic run_block(input bit gaps, input bit ld_run,
                           input int abort_at);
    int k = 0;
    int cyc = 0;
    int post = 0;
    bit acc_p = 1'b0;
    bit seen = 1'b0;
    done_cnt = 0;
    while (post < 12) begin
      @(negedge iClock);
      if (acc_p) k++;
      acc_p = 1'b0;
      if (oDone) begin
        done_cnt++;
        seen = 1'b1;
      end
      if (seen) post++;
      cyc++;
      if (cyc > 2000) begin
        chk("timeout", 0, 1);
        break;
      end
      iLoad = 1'b0;
      if (abort_at > 0 && k == abort_at) begin
        iReset = 1'b1; iEnable = 1'b0; iValid = 1'b0;
        @(negedge iClock);
        iReset = 1'b0;
        model_clear();
        repeat (40) begin
          iEnable = 1'b1;
          @(negedge iClock);
          if (oDone) done_cnt++;
        end
        chk("abort_done", done_cnt, 0);
        chk("abort_pred", oBestPredictor, 0);
        chk("abort_err", oBestError, 0);
        chk("abort_busy", oBusy, 0);
        return;
      end
      iEnable = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k < BS) begin
        iValid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        iSample = SW'(xs[k]);
        iShift  = (k == 0) ? 5'(sh) : 5'($urandom);
        acc_p   = iEnable && iValid;
        if (ld_run && k == 5) begin
          iLoad  = 1'b1;
          iM     = 4'(1 + $urandom_range(0, 11));
          iCoeff = 12'($urandom);
        end
      end else begin
        iValid  = (!seen && gaps) ? 1'($urandom_range(0, 1)) : 1'b0;
        iSample = 16'($urandom);
      end
    end
    iValid = 1'b0;
  endtask

  task automatic block(input string tag, input bit gaps, input bit ld_run);
    model();
    run_block(gaps, ld_run, 0);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_pred"}, oBestPredictor, m_bp);
    chk({tag, "_err"}, oBestError, m_be);
    chk({tag, "_busy"}, oBusy, 0);
  endtask

  task automatic rand_xs();
    for (int i = 0; i < BS; i++)
      xs[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1; iEnable = 1'b0; iLoad = 1'b0; iM = '0;
    iCoeff = '0; iShift = '0; iValid = 1'b0; iSample = '0;
    model_clear();
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    iEnable = 1'b1;
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_pred", oBestPredictor, 0);
    chk("rst_err", oBestError, 0);

    sh = 0;
    for (int i = 0; i < BS; i++) xs[i] = 100;
    block("const100", 0, 0);
    chk("const100_bp", oBestPredictor, 12);
    chk("const100_be", oBestError, 400);

    do_reset();
    load(1, 1);
    load(2, 2);
    load(2, -1);
    for (int i = 0; i < BS; i++) xs[i] = i;
    block("ramp", 0, 0);
    for (int i = 0; i < BS; i++) xs[i] = 7;
    block("tie", 0, 0);
    chk("tie_bp", oBestPredictor, 1);
    chk("tie_be", oBestError, 0);

    do_reset();
    load(1, 2);
    sh = 1;
    for (int i = 0; i < BS; i++) xs[i] = -50;
    block("ashr", 0, 0);
    chk("ashr_bp", oBestPredictor, 1);
    chk("ashr_be", oBestError, 0);

    do_reset();
    for (int i = 0; i < 13; i++)
      load(12, int'($urandom_range(0, 16)) - 8);
    load(0, 5);
    load(13, 3);
    load(15, -3);
    sh = 2;
    rand_xs();
    block("ld12", 1, 1);

    do_reset();
    for (int m = 1; m <= MO; m++)
      for (int j = 0; j < m; j++)
        load(m, int'($urandom_range(0, 16)) - 8);
    sh = 3;
    for (int r = 0; r < 3; r++) begin
      rand_xs();
      block("nogap", 0, 0);
      sv_bp = oBestPredictor;
      sv_be = oBestError;
      block("gap", 1, 1);
      chk("gap_same_pred", oBestPredictor, sv_bp);
      chk("gap_same_err", oBestError, sv_be);
    end

    rand_xs();
    run_block(1, 0, 8);
    sh = 0;
    rand_xs();
    block("post_abort", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
